// File: rtl/gray_seq_checker_if.sv
// Gray sample stream and checker result bus.
// Ports (master drives the sample side, slave drives the results):
//   gray_in, valid_in, sync_clr       : sample stream and reference clear
//   bin_out, valid_out, dir_up, hold,
//   step_err, err_count, locked       : registered checker results
interface gray_seq_checker_if #(
   parameter int unsigned N         = 4,
   parameter int unsigned ERR_CNT_W = 8
);
   logic [N-1:0]         gray_in;
   logic                 valid_in;
   logic                 sync_clr;
   logic [N-1:0]         bin_out;
   logic                 valid_out;
   logic                 dir_up;
   logic                 hold;
   logic                 step_err;
   logic [ERR_CNT_W-1:0] err_count;
   logic                 locked;

   modport master (
      output gray_in, valid_in, sync_clr,
      input  bin_out, valid_out, dir_up, hold, step_err, err_count, locked
   );

   modport slave (
      input  gray_in, valid_in, sync_clr,
      output bin_out, valid_out, dir_up, hold, step_err, err_count, locked
   );
endinterface

// File: rtl/gray_seq_checker.sv
// Gray sequence checker: converts each Gray sample to binary, registers it and
// checks that it is +1, -1 or a repeat (mod 2^N) of the previous sample.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of gray_seq_checker_if (samples in, results out)
module gray_seq_checker #(
   parameter int unsigned N         = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   gray_seq_checker_if.slave bus
);

   typedef enum logic {IDLE, TRACK} state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         bin_c;
   logic [N-1:0]         prev_q, prev_d;
   logic [N-1:0]         bin_q, bin_d;
   logic                 vout_q, vout_d;
   logic                 dir_q, dir_d;
   logic                 hold_q, hold_d;
   logic                 serr_q, serr_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
   logic                 lock_q, lock_d;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
   always_comb begin
      bin_c = '0;
      for (int i = 0; i < int'(N); i++) begin
         bin_c[i] = ^(bus.gray_in >> i);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state: clear drops the reference, any accepted sample becomes one
   always_comb begin
      state_d = state_q;
      if (bus.sync_clr)      state_d = IDLE;
      else if (bus.valid_in) state_d = TRACK;
   end

   // Next values of the registered outputs and reference sample
   always_comb begin
      bin_d  = bin_q;
      prev_d = prev_q;
      dir_d  = dir_q;
      cnt_d  = cnt_q;
      vout_d = 1'b0;
      hold_d = 1'b0;
      serr_d = 1'b0;
      lock_d = (state_d == TRACK);
      if (bus.sync_clr) begin
         cnt_d = '0;
      end else if (bus.valid_in) begin
         vout_d = 1'b1;
         bin_d  = bin_c;
         prev_d = bin_c;
         if (state_q == TRACK) begin
            // +1 tested first so that N=1 toggles report upward
            if (bin_c == prev_q + N'(1)) begin
               dir_d = 1'b1;
            end else if (bin_c == prev_q - N'(1)) begin
               dir_d = 1'b0;
            end else if (bin_c == prev_q) begin
               hold_d = 1'b1;
            end else begin
               serr_d = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
            end
         end
      end
   end

   // Output and reference registers
   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= '0;
         prev_q <= '0;
         vout_q <= 1'b0;
         dir_q  <= 1'b0;
         hold_q <= 1'b0;
         serr_q <= 1'b0;
         cnt_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         prev_q <= prev_d;
         vout_q <= vout_d;
         dir_q  <= dir_d;
         hold_q <= hold_d;
         serr_q <= serr_d;
         cnt_q  <= cnt_d;
         lock_q <= lock_d;
      end
   end

   assign bus.bin_out   = bin_q;
   assign bus.valid_out = vout_q;
   assign bus.dir_up    = dir_q;
   assign bus.hold      = hold_q;
   assign bus.step_err  = serr_q;
   assign bus.err_count = cnt_q;
   assign bus.locked    = lock_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Testbench for gray_seq_checker (N=4, ERR_CNT_W=2): directed steps with a
// behavioural model feeding an expected-result queue, plus directed constants.
module tb_gray_seq_checker;

   localparam int unsigned N  = 4;
   localparam int unsigned EW = 2;

   typedef struct packed {
      logic [N-1:0]  bin;
      logic          vo;
      logic          dir;
      logic          hold;
      logic          serr;
      logic [EW-1:0] cnt;
      logic          lock;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gray_seq_checker_if #(.N(N), .ERR_CNT_W(EW)) bus ();

   gray_seq_checker #(.N(N), .ERR_CNT_W(EW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_cmp = 0;
   int   n_err = 0;
   int   n_step = 0;
   exp_t sb[$];

   // Behavioural model state
   logic          m_track;
   logic [N-1:0]  m_prev;
   exp_t          m;

   function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
      logic [N-1:0] b;
      b[N-1] = g[N-1];
      for (int i = int'(N) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model one clock edge from the inputs being driven
   task automatic model(input logic [N-1:0] g, input logic v, input logic c, input logic r);
      logic [N-1:0] b;
      b = g2b(g);
      m.vo = 1'b0; m.hold = 1'b0; m.serr = 1'b0;
      if (r) begin
         m = '0; m_track = 1'b0; m_prev = '0;
      end else if (c) begin
         m_track = 1'b0; m.lock = 1'b0; m.cnt = '0;
      end else if (v) begin
         m.vo = 1'b1;
         if (m_track) begin
            if (b == N'(m_prev + 1))      m.dir = 1'b1;
            else if (b == N'(m_prev - 1)) m.dir = 1'b0;
            else if (b == m_prev)         m.hold = 1'b1;
            else begin
               m.serr = 1'b1;
               if (m.cnt != {EW{1'b1}}) m.cnt = m.cnt + 1'b1;
            end
         end
         m.bin = b; m_prev = b; m_track = 1'b1; m.lock = 1'b1;
      end
   endtask

   // Drive one cycle, push the expectation, then compare after the edge
   task automatic step(input logic [N-1:0] g, input logic v, input logic c, input logic r);
      exp_t e;
      string s;
      @(negedge clk);
      bus.gray_in = g; bus.valid_in = v; bus.sync_clr = c; rst = r;
      model(g, v, c, r);
      sb.push_back(m);
      @(posedge clk);
      #1;
      n_step++;
      s = $sformatf("s%0d", n_step);
      e = sb.pop_front();
      chk({s, "_bin_out"},   32'(bus.bin_out),   32'(e.bin));
      chk({s, "_valid_out"}, 32'(bus.valid_out), 32'(e.vo));
      chk({s, "_dir_up"},    32'(bus.dir_up),    32'(e.dir));
      chk({s, "_hold"},      32'(bus.hold),      32'(e.hold));
      chk({s, "_step_err"},  32'(bus.step_err),  32'(e.serr));
      chk({s, "_err_count"}, 32'(bus.err_count), 32'(e.cnt));
      chk({s, "_locked"},    32'(bus.locked),    32'(e.lock));
   endtask

   initial begin
      logic [N-1:0] up_seq [17];
      logic [N-1:0] dn_seq [4];
      int           serr_pulses;
      up_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
      dn_seq = '{4'h8, 4'h9, 4'hB, 4'hA};
      m = '0; m_track = 1'b0; m_prev = '0;
      bus.gray_in = '0; bus.valid_in = 1'b0; bus.sync_clr = 1'b0; rst = 1'b1;

      // Reset state
      step(4'h0, 1'b0, 1'b0, 1'b1);
      step(4'h0, 1'b0, 1'b0, 1'b1);
      chk("reset_locked", 32'(bus.locked), 32'd0);

      // Full up sequence with wrap 8 -> 0
      for (int i = 0; i < 17; i++) begin
         step(up_seq[i], 1'b1, 1'b0, 1'b0);
         if (i == 0) begin
            chk("up_first_locked", 32'(bus.locked), 32'd1);
            chk("up_first_dir",    32'(bus.dir_up), 32'd0);
         end
         if (i == 16) begin
            chk("up_wrap_bin", 32'(bus.bin_out),  32'd0);
            chk("up_wrap_dir", 32'(bus.dir_up),   32'd1);
            chk("up_wrap_err", 32'(bus.step_err), 32'd0);
         end
      end
      chk("up_err_count", 32'(bus.err_count), 32'd0);

      // Down sequence from 0: F,E,D,C
      for (int i = 0; i < 4; i++) step(dn_seq[i], 1'b1, 1'b0, 1'b0);
      chk("dn_bin", 32'(bus.bin_out), 32'hC);
      chk("dn_dir", 32'(bus.dir_up),  32'd0);

      // Illegal single-bit Gray change 0001 -> 0101, then legal +1
      step(4'h0, 1'b0, 1'b1, 1'b0);
      step(4'h1, 1'b1, 1'b0, 1'b0);
      chk("ill_first_unchecked", 32'(bus.step_err), 32'd0);
      step(4'h5, 1'b1, 1'b0, 1'b0);
      chk("ill_bin",  32'(bus.bin_out),   32'd6);
      chk("ill_err",  32'(bus.step_err),  32'd1);
      chk("ill_cnt",  32'(bus.err_count), 32'd1);
      step(4'h4, 1'b1, 1'b0, 1'b0);
      chk("ill_next_ok", 32'(bus.step_err), 32'd0);

      // Repeat across a two-cycle gap (first gray 3 is a jump from 7)
      step(4'h3, 1'b1, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0, 1'b0);
      chk("gap_valid_out", 32'(bus.valid_out), 32'd0);
      step(4'h3, 1'b0, 1'b0, 1'b0);
      step(4'h3, 1'b1, 1'b0, 1'b0);
      chk("gap_hold", 32'(bus.hold), 32'd1);

      // sync_clr wins over a same-cycle sample
      chk("pre_clr_cnt", 32'(bus.err_count), 32'd2);
      step(4'hF, 1'b1, 1'b1, 1'b0);
      chk("clr_locked", 32'(bus.locked),    32'd0);
      chk("clr_cnt",    32'(bus.err_count), 32'd0);
      chk("clr_bin",    32'(bus.bin_out),   32'd2);
      step(4'h0, 1'b1, 1'b0, 1'b0);
      chk("clr_next_unchecked", 32'(bus.step_err), 32'd0);

      // Saturation: four jumps 0 <-> 5
      serr_pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step((i % 2 == 0) ? 4'h7 : 4'h0, 1'b1, 1'b0, 1'b0);
         if (bus.step_err === 1'b1) serr_pulses++;
      end
      chk("sat_cnt",    32'(bus.err_count), 32'd3);
      chk("sat_pulses", 32'(serr_pulses),   32'd4);

      // Reset mid-stream with a sample present, then first sample unflagged
      step(4'h7, 1'b1, 1'b0, 1'b1);
      chk("rst_bin", 32'(bus.bin_out),   32'd0);
      chk("rst_cnt", 32'(bus.err_count), 32'd0);
      step(4'hC, 1'b1, 1'b0, 1'b0);
      chk("rst_next_unchecked", 32'(bus.step_err), 32'd0);

      // Mixed random traffic against the model
      for (int i = 0; i < 60; i++) begin
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 15) == 0), 1'b0);
      end

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
